// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared states, constants and helpers for the APB responder
package apb_pkg;

  localparam int NSEL         = 3;
  localparam int ERR_MAX      = 255;
  localparam int NREG_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  // True when exactly one select line is active.
  function automatic logic is_onehot(input logic [NSEL-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/apb_reg_bank.sv
// rtl/apb_reg_bank.sv - one bank of 32-bit registers, one write port, async read
module apb_reg_bank #(
  parameter int NREG = 16,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [NREG];

  // Register array; cleared asynchronously, written on a committed access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/apb_responder.sv
// rtl/apb_responder.sv - zero-wait APB responder with three register banks and protocol checker
module apb_responder
  import apb_pkg::*;
#(
  parameter int NREG = NREG_DEFAULT,
  parameter int AW   = $clog2(NREG)
) (
  input  logic            Hclk,
  input  logic            Hresetn,
  input  logic [NSEL-1:0] Pselx,
  input  logic            Penable,
  input  logic            Pwrite,
  input  logic [31:0]     Paddr,
  input  logic [31:0]     Pwdata,
  output logic [31:0]     Prdata,
  output logic            prot_err,
  output logic [7:0]      err_count
);

  // The state register lags the bus by one cycle: ST_SETUP means the setup
  // phase was seen last cycle, so the bus must now be in its access phase.
  apb_state_e      state_q, state_d;
  logic [NSEL-1:0] sel_q, sel_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            write_q, write_d;
  logic [31:0]     prdata_q, prdata_d;
  logic            prot_err_q;
  logic [7:0]      err_cnt_q;

  logic            viol;
  logic            start_setup;
  logic            wr_commit;
  logic            sel_onehot;
  logic            sel_multi;
  logic [AW-1:0]   addr_word;
  logic [31:0]     mux_rdata;
  logic [31:0]     bank_rdata [NSEL];

  logic            unused_addr_bits;
  assign unused_addr_bits = ^{Paddr[31:AW+2], Paddr[1:0]};

  assign addr_word  = Paddr[AW+1:2];
  assign sel_onehot = is_onehot(Pselx);
  assign sel_multi  = (|Pselx) && !sel_onehot;

  for (genvar g = 0; g < NSEL; g++) begin : g_bank
    apb_reg_bank #(
      .NREG (NREG),
      .AW   (AW)
    ) u_bank (
      .clk   (Hclk),
      .rst_n (Hresetn),
      .we    (wr_commit && sel_q[g]),
      .waddr (addr_q),
      .wdata (Pwdata),
      .raddr (addr_word),
      .rdata (bank_rdata[g])
    );
  end

  // Select the addressed bank for a read being set up this cycle.
  always_comb begin
    mux_rdata = '0;
    for (int i = 0; i < NSEL; i++) begin
      if (Pselx[i]) begin
        mux_rdata = mux_rdata | bank_rdata[i];
      end
    end
  end

  // Next-state, violation detection and write commit.
  always_comb begin
    state_d     = ST_IDLE;
    sel_d       = sel_q;
    addr_d      = addr_q;
    write_d     = write_q;
    viol        = 1'b0;
    start_setup = 1'b0;
    wr_commit   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sel_multi || Penable) begin
          viol = 1'b1;
        end else if (sel_onehot) begin
          start_setup = 1'b1;
        end
      end
      ST_SETUP: begin
        if (Penable && (Pselx == sel_q) && (addr_word == addr_q) &&
            (Pwrite == write_q)) begin
          state_d   = ST_ACCESS;
          wr_commit = write_q;
        end else begin
          viol = 1'b1;
        end
      end
      ST_ACCESS: begin
        if (Pselx == '0) begin
          viol = Penable;
        end else if (sel_onehot && !Penable) begin
          start_setup = 1'b1;
        end else begin
          viol = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (start_setup) begin
      state_d = ST_SETUP;
      sel_d   = Pselx;
      addr_d  = addr_word;
      write_d = Pwrite;
    end
  end

  // Read data is launched at the end of a read setup so it holds through access.
  always_comb begin
    prdata_d = (start_setup && !Pwrite) ? mux_rdata : '0;
  end

  // Transfer tracking registers and read data.
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state_q  <= ST_IDLE;
      sel_q    <= '0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      prdata_q <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      prdata_q <= prdata_d;
    end
  end

  // Sticky error flag and saturating violation counter.
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      prot_err_q <= 1'b0;
      err_cnt_q  <= '0;
    end else if (viol) begin
      prot_err_q <= 1'b1;
      if (err_cnt_q != 8'(ERR_MAX)) begin
        err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

  assign Prdata    = prdata_q;
  assign prot_err  = prot_err_q;
  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_apb_responder.sv
// tb/tb_apb_responder.sv - directed self-checking bench for apb_responder
module tb_apb_responder;

  logic        Hclk;
  logic        Hresetn;
  logic [2:0]  Pselx;
  logic        Penable;
  logic        Pwrite;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;
  logic [31:0] Prdata;
  logic        prot_err;
  logic [7:0]  err_count;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  apb_responder #(.NREG(16)) dut (
    .Hclk      (Hclk),
    .Hresetn   (Hresetn),
    .Pselx     (Pselx),
    .Penable   (Penable),
    .Pwrite    (Pwrite),
    .Paddr     (Paddr),
    .Pwdata    (Pwdata),
    .Prdata    (Prdata),
    .prot_err  (prot_err),
    .err_count (err_count)
  );

  initial Hclk = 1'b0;
  always #5 Hclk = ~Hclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] s, input logic en, input logic wr,
                       input logic [31:0] a, input logic [31:0] d);
    @(negedge Hclk);
    Pselx   = s;
    Penable = en;
    Pwrite  = wr;
    Paddr   = a;
    Pwdata  = d;
    #1;
  endtask

  task automatic do_write(input logic [2:0] s, input logic [31:0] a, input logic [31:0] d);
    drive(s, 1'b0, 1'b1, a, d);
    drive(s, 1'b1, 1'b1, a, d);
    drive(3'b000, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic do_read(input logic [2:0] s, input logic [31:0] a,
                         input logic [31:0] exp, input string tag);
    drive(s, 1'b0, 1'b0, a, 32'h0);
    drive(s, 1'b1, 1'b0, a, 32'h0);
    chk(tag, Prdata, exp);
    drive(3'b000, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    Hresetn = 1'b0;
    Pselx   = '0;
    Penable = 1'b0;
    Pwrite  = 1'b0;
    Paddr   = '0;
    Pwdata  = '0;
    #12;
    chk("reset_prdata", Prdata, 32'h0);
    chk("reset_prot_err", {31'h0, prot_err}, 32'h0);
    chk("reset_err_count", {24'h0, err_count}, 32'h0);

    // Release reset together with the first setup phase.
    @(negedge Hclk);
    Hresetn = 1'b1;
    Pselx   = 3'b001;
    Penable = 1'b0;
    Pwrite  = 1'b1;
    Paddr   = 32'h0000_0008;
    Pwdata  = 32'hDEAD_BEEF;
    drive(3'b001, 1'b1, 1'b1, 32'h0000_0008, 32'hDEAD_BEEF);
    drive(3'b000, 1'b0, 1'b0, 32'h0, 32'h0);

    // Write-then-read with Prdata zero around the access cycle.
    drive(3'b001, 1'b0, 1'b0, 32'h0000_0008, 32'h0);
    chk("rd8_setup_zero", Prdata, 32'h0);
    drive(3'b001, 1'b1, 1'b0, 32'h0000_0008, 32'h0);
    chk("rd8_access", Prdata, 32'hDEAD_BEEF);
    drive(3'b000, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("rd8_after_zero", Prdata, 32'h0);
    chk("rd8_prot_err", {31'h0, prot_err}, 32'h0);

    // Bank isolation.
    do_write(3'b001, 32'h4, 32'h1111_1111);
    do_write(3'b100, 32'h4, 32'h2222_2222);
    do_read(3'b010, 32'h4, 32'h0, "bank1_empty");
    do_read(3'b100, 32'h4, 32'h2222_2222, "bank2_val");
    do_read(3'b001, 32'h4, 32'h1111_1111, "bank0_val");

    // Back-to-back write access directly followed by read setup.
    drive(3'b010, 1'b0, 1'b1, 32'h10, 32'hCAFE_F00D);
    drive(3'b010, 1'b1, 1'b1, 32'h10, 32'hCAFE_F00D);
    drive(3'b010, 1'b0, 1'b0, 32'h10, 32'h0);
    drive(3'b010, 1'b1, 1'b0, 32'h10, 32'h0);
    chk("b2b_read", Prdata, 32'hCAFE_F00D);
    drive(3'b000, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("b2b_no_err", {24'h0, err_count}, 32'h0);

    // Address aliasing and ignored byte offset.
    do_write(3'b001, 32'h8000_0044, 32'hA5A5_A5A5);
    do_read(3'b001, 32'h0000_0004, 32'hA5A5_A5A5, "alias_read");
    do_read(3'b001, 32'h0000_0007, 32'hA5A5_A5A5, "byte_offset_read");

    // Multi-select, then Penable in IDLE.
    drive(3'b011, 1'b0, 1'b1, 32'h4, 32'hFFFF_FFFF);
    drive(3'b001, 1'b1, 1'b1, 32'h4, 32'hFFFF_FFFF);
    drive(3'b000, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("viol_prot_err", {31'h0, prot_err}, 32'h1);
    chk("viol_err_count2", {24'h0, err_count}, 32'd2);

    // Address change between setup and access must not write.
    drive(3'b001, 1'b0, 1'b1, 32'h8, 32'h9999_9999);
    drive(3'b001, 1'b1, 1'b1, 32'hC, 32'h9999_9999);
    drive(3'b000, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("viol_err_count3", {24'h0, err_count}, 32'd3);

    // Enable still low in the second cycle of a held select.
    drive(3'b001, 1'b0, 1'b1, 32'hC, 32'h7777_7777);
    drive(3'b001, 1'b0, 1'b1, 32'hC, 32'h7777_7777);
    drive(3'b000, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("viol_err_count4", {24'h0, err_count}, 32'd4);

    do_read(3'b001, 32'h4, 32'hA5A5_A5A5, "no_write_on_viol_4");
    do_read(3'b001, 32'h8, 32'hDEAD_BEEF, "no_write_on_viol_8");
    do_read(3'b001, 32'hC, 32'h0, "no_write_on_viol_C");

    // Saturation.
    for (int i = 0; i < 300; i++) begin
      drive(3'b000, 1'b1, 1'b0, 32'h0, 32'h0);
    end
    drive(3'b000, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("err_saturate", {24'h0, err_count}, 32'd255);

    // Asynchronous reset in the middle of a write access.
    drive(3'b001, 1'b0, 1'b1, 32'hC, 32'h1234_5678);
    drive(3'b001, 1'b1, 1'b1, 32'hC, 32'h1234_5678);
    #2;
    Hresetn = 1'b0;
    #1;
    chk("async_rst_prdata", Prdata, 32'h0);
    chk("async_rst_prot_err", {31'h0, prot_err}, 32'h0);
    chk("async_rst_err_count", {24'h0, err_count}, 32'h0);
    drive(3'b000, 1'b0, 1'b0, 32'h0, 32'h0);
    Hresetn = 1'b1;
    do_read(3'b001, 32'hC, 32'h0, "aborted_write");
    do_read(3'b001, 32'h8, 32'h0, "bank_cleared");
    chk("post_rst_prot_err", {31'h0, prot_err}, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/apb_responder.md
APB_RESPONDER -- requirements
Module: apb_responder

Interface
REQ-001 The block SHALL take parameter NREG, default 16, meaning the number of 32-bit registers per select bank (power of two, 2..64).
REQ-002 The block SHALL take parameter AW, default log2(NREG), meaning the word-address width taken from Paddr[AW+1:2].
REQ-003 Port: Hclk  input  1  single system clock; all state updates on its rising edge.
REQ-004 Port: Hresetn  input  1  reset, asynchronous and active-low.
REQ-005 Port: Pselx  input  3  one-hot APB select; bit i addresses bank i.
REQ-006 Port: Penable  input  1  APB enable, high in the ACCESS phase.
REQ-007 Port: Pwrite  input  1  1 = write, 0 = read.
REQ-008 Port: Paddr  input  32  APB address; only Paddr[AW+1:2] is decoded.
REQ-009 Port: Pwdata  input  32  APB write data.
REQ-010 Port: Prdata  output  32  APB read data, registered.
REQ-011 Port: prot_err  output  1  sticky protocol-violation flag.
REQ-012 Port: err_count  output  8  saturating count of protocol violations.

Function
REQ-013 The FSM SHALL have states IDLE, SETUP and ACCESS.
REQ-014 IDLE -> SETUP SHALL occur when exactly one Pselx bit is set and Penable=0.
REQ-015 SETUP -> ACCESS SHALL occur when Penable=1 and Pselx, Paddr and Pwrite equal the values captured in SETUP.
REQ-016 ACCESS SHALL be exactly one cycle (zero wait states, no Pready).
REQ-017 ACCESS -> SETUP SHALL occur when a one-hot Pselx is present with Penable=0 (back-to-back transfer).
REQ-018 ACCESS -> IDLE SHALL occur when Pselx=0.
REQ-019 Any other condition SHALL return the FSM to IDLE and count one violation.
REQ-020 A violation SHALL be any of the following:
  - Pselx not one-hot and nonzero;
  - Penable=1 while in IDLE;
  - Penable=0 in SETUP with the select held;
  - Paddr, Pwrite or Pselx changing between SETUP and ACCESS;
  - Penable=1 with Pselx=0.
REQ-021 On each violation, prot_err SHALL be set and err_count SHALL increment, saturating at 255; a single cycle counts at most one violation.
REQ-022 A write SHALL commit Pwdata to bank[sel][Paddr[AW+1:2]] at the rising edge ending the ACCESS cycle.
REQ-023 A violating ACCESS SHALL NOT write.
REQ-024 On the edge ending a valid read SETUP, Prdata SHALL be loaded from bank[sel][Paddr[AW+1:2]], so that Prdata is stable for the whole ACCESS cycle.
REQ-025 Prdata SHALL be 0 in every cycle that is not the ACCESS of a valid read.
REQ-026 A read in SETUP immediately following a write ACCESS to the same address SHALL return the newly written data.
REQ-027 Paddr[1:0] and Paddr[31:AW+2] SHALL be ignored; addresses alias modulo NREG words.
REQ-028 Reads SHALL be side-effect free.

Reset
REQ-029 When Hresetn=0, the following SHALL take effect immediately, without a clock edge:
  - FSM = IDLE;
  - Prdata = 0;
  - prot_err = 0;
  - err_count = 0;
  - all registers in every bank = 0.
REQ-030 Reset asserted mid-transfer SHALL abort it with no register write.
REQ-031 The first SETUP SHALL be accepted on the first rising edge after Hresetn deasserts.

Structure
REQ-032 The state enum and the constants NSEL=3, ERR_MAX=255 and the default NREG SHALL live in a shared package, apb_pkg.
REQ-033 Each bank SHALL be one instance of sub-module apb_reg_bank with ports: clock, reset, write enable, write address, write data, read address, read data.
REQ-034 apb_responder SHALL instantiate three apb_reg_bank instances, one per Pselx bit, and hold the FSM, the violation checker and the read mux.

Verification
REQ-035 Write then read: Pselx=001, write 0xDEADBEEF to Paddr 0x0000_0008, then read 0x0000_0008 -> Prdata=0xDEADBEEF during the read ACCESS cycle and 0 in the cycles around it; prot_err=0.
REQ-036 Bank isolation: write 0x11111111 to bank 0 at 0x4 and 0x22222222 to bank 2 at 0x4; read bank 1 at 0x4 -> 0; read bank 2 at 0x4 -> 0x22222222.
REQ-037 Back-to-back: a write ACCESS at 0x10 followed directly by a read SETUP at 0x10 -> read returns the written value; the FSM goes ACCESS -> SETUP with no IDLE cycle.
REQ-038 Violations: drive Pselx=011 with Penable=0, then Penable=1 in IDLE -> prot_err=1, err_count=2, and no register changes.
REQ-039 Saturation and reset: generate 300 violations -> err_count=255; assert Hresetn=0 asynchronously between clock edges during a write ACCESS -> all outputs 0 immediately and the target register remains 0.
REQ-040 Aliasing: with NREG=16, write 0xA5A5A5A5 to 0x8000_0044; read 0x0000_0004 on the same select -> 0xA5A5A5A5.
